mseq_checker: RTL and testbench
===============================

# mseq_checker

Serial M-sequence checker that sits directly downstream of the 5-bit LFSR M-sequence generator (recurrence b[n] = b[n-2] XOR b[n-5], period 31) and consumes its one-bit output stream. It self-synchronises to the incoming stream, declares lock after a run of correct predictions, then free-runs a local replica and counts bit errors. It declares loss of lock after a run of consecutive mismatches.

## Interface
- LOCK_N, default 8: consecutive correct predictions in CHECK required to lock (1..31)
- UNLOCK_N, default 4: consecutive mismatches in LOCKED that drop lock (1..31)
- CNT_W, default 16: error counter width (>=2)
- clk  input  1  sole clock, rising edge
- preset  input  1  synchronous, active-low reset
- bit_en  input  1  din is valid this cycle; all state advances only when 1
- din  input  1  received sequence bit
- err_clr  input  1  synchronous clear of err_cnt
- locked  output  1  registered lock status
- err  output  1  one-cycle pulse per mismatch detected while LOCKED
- err_cnt  output  CNT_W  saturating mismatch count

## Operation
- 5-bit history register r; r[4] newest, r[0] oldest; pred = r[3] XOR r[0].
- FSM states HUNT, CHECK, LOCKED; fill counter 0..5; run counter for match/miss runs.
- HUNT: on bit_en, r <= {din, r[4:1]}, fill++; on the 5th bit -> CHECK, run = 0.
- CHECK: on bit_en, r <= {din, r[4:1]}; match = (din == pred) AND (r != 0). Match: run++, reaching LOCK_N -> LOCKED, run = 0. Mismatch: run = 0, stay in CHECK. An all-zero history never counts as a match.
- LOCKED: din no longer enters r; r <= {pred, r[4:1]} (local replica). din != pred: err = 1, err_cnt +1 (saturates at all-ones), run++. Match: run = 0. run reaching UNLOCK_N -> HUNT, r = 0, fill = 0, run = 0.
- The replica continues across errors, so a single flipped bit produces exactly one error.
- err_cnt survives lock loss. It clears only on preset or err_clr. err_clr has priority over a simultaneous increment, so the result is 0.
- bit_en = 0: every register holds and err = 0.

## Timing
- Reset (preset = 0 at a rising edge): state HUNT, r = 0, fill = 0, run = 0, locked = 0, err = 0, err_cnt = 0. Applies mid-operation from any state.
- All outputs are registered. err and locked change on the edge that samples the deciding bit, so they are visible one cycle after that din.
- A clean stream with bit_en held high gives minimum lock latency of 5 + LOCK_N bit_en cycles: 13 with defaults.
- Unlock: locked falls on the edge that samples the UNLOCK_N-th consecutive mismatch. That mismatch still pulses err and increments err_cnt.
- No back-pressure; din is accepted on every bit_en.

## Configuration
- MSEQ_CHK_ERRCNT_EN defined: err_cnt counter and err_clr are implemented as described.
- MSEQ_CHK_ERRCNT_EN not defined: no counter is built, err_cnt is tied to 0 and err_clr is ignored. err, locked and the FSM are unchanged.

## Structure
- Shared package holds:
  - the FSM state enum (HUNT, CHECK, LOCKED)
  - constant MSEQ_W = 5
  - the tap positions (3, 0)
  - constant MSEQ_PERIOD = 31
- One sub-module, mseq_ref5, holds r and the pred XOR. Its inputs are load-select (din or pred), shift enable and clear.
- The FSM, run/fill counters and error counter live in mseq_checker.

## Test plan
- Generator output from preset state 11111 (1,1,1,1,1,0,0,1,1,0,1,...), bit_en = 1 -> locked rises after the 13th bit; err stays 0 over 100 periods; err_cnt = 0.
- Locked, invert one bit -> exactly one err pulse, err_cnt = 1, locked stays 1.
- Locked, invert 4 consecutive bits -> err_cnt = 4, locked falls after the 4th inverted bit. Clean stream afterwards -> relock 13 bit_en cycles later, err_cnt still 4.
- din constant 0 for 200 bits -> never locks, err = 0.
- bit_en toggling 1/0 with a clean stream -> lock after exactly 13 enabled bits; no state change on bit_en = 0 cycles.
- CNT_W = 2, continuous errors with UNLOCK_N = 31 -> err_cnt saturates at 3. err_clr during a mismatch cycle -> err_cnt = 0. preset mid-lock -> all outputs 0 on the next cycle.

Source files
------------

// File: rtl/mseq_checker_pkg.sv
// Shared types and constants for the 5-bit M-sequence checker.
// Latency: n/a (package). Backpressure: n/a.
// Recurrence b[n] = b[n-2] ^ b[n-5] maps onto history taps r[3] and r[0].
package mseq_checker_pkg;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        CHECK  = 2'd1,
        LOCKED = 2'd2
    } state_t;

    localparam int MSEQ_W      = 5;
    localparam int TAP_HI      = 3;
    localparam int TAP_LO      = 0;
    localparam int MSEQ_PERIOD = 31;

endpackage

// File: rtl/mseq_ref5.sv
// History register and next-bit predictor; shifts in din or its own prediction.
// Latency: pred is combinational from r; r updates one edge after shift.
// Backpressure: none, shifts whenever shift is high; clr wins over shift.
module mseq_ref5
    import mseq_checker_pkg::*;
(
    input  logic              clk,
    input  logic              preset,
    input  logic              clr,
    input  logic              shift,
    input  logic              sel_pred,
    input  logic              din,
    output logic [MSEQ_W-1:0] r,
    output logic              pred
);

    assign pred = r[TAP_HI] ^ r[TAP_LO];

    // r[MSEQ_W-1] holds the newest bit, r[0] the oldest.
    always_ff @(posedge clk) begin
        if (!preset || clr) begin
            r <= '0;
        end else if (shift) begin
            r <= {(sel_pred ? pred : din), r[MSEQ_W-1:1]};
        end
    end

endmodule

// File: rtl/mseq_checker.sv
// Self-synchronising M-sequence checker with lock FSM; MSEQ_CHK_ERRCNT_EN builds err_cnt/err_clr.
// Latency: locked/err registered, visible one cycle after the deciding din.
// Backpressure: none; din is consumed on every bit_en, all state holds when bit_en = 0.
module mseq_checker
    import mseq_checker_pkg::*;
#(
    parameter int LOCK_N   = 8,
    parameter int UNLOCK_N = 4,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             preset,
    input  logic             bit_en,
    input  logic             din,
    input  logic             err_clr,
    output logic             locked,
    output logic             err,
    output logic [CNT_W-1:0] err_cnt
);

    localparam logic [4:0] LOCK_V   = 5'(LOCK_N);
    localparam logic [4:0] UNLOCK_V = 5'(UNLOCK_N);

    state_t            state, state_nxt;
    logic [2:0]        fill, fill_nxt;
    logic [4:0]        run, run_nxt, run_inc;
    logic [MSEQ_W-1:0] r;
    logic              pred;
    logic              ref_shift, ref_sel_pred, ref_clr;
    logic              hit, miss, drop;

    mseq_ref5 u_ref (
        .clk      (clk),
        .preset   (preset),
        .clr      (ref_clr),
        .shift    (ref_shift),
        .sel_pred (ref_sel_pred),
        .din      (din),
        .r        (r),
        .pred     (pred)
    );

    assign run_inc = run + 5'd1;

    always_ff @(posedge clk) begin
        if (!preset) begin
            state  <= HUNT;
            fill   <= 3'd0;
            run    <= 5'd0;
            locked <= 1'b0;
            err    <= 1'b0;
        end else begin
            state  <= state_nxt;
            fill   <= fill_nxt;
            run    <= run_nxt;
            locked <= (state_nxt == LOCKED);
            err    <= miss;
        end
    end

    // An all-zero history is the LFSR lock-up state and never counts as a match.
    always_comb begin
        ref_shift    = bit_en;
        ref_sel_pred = (state == LOCKED);
        hit          = (din == pred) && (r != '0);
        miss         = bit_en && (state == LOCKED) && (din != pred);
        drop         = miss && (run_inc == UNLOCK_V);
        ref_clr      = drop;
    end

    always_comb begin
        state_nxt = state;
        fill_nxt  = fill;
        run_nxt   = run;
        if (bit_en) begin
            case (state)
                HUNT: begin
                    fill_nxt = fill + 3'd1;
                    if (fill == 3'd4) begin
                        state_nxt = CHECK;
                        run_nxt   = 5'd0;
                    end
                end
                CHECK: begin
                    if (!hit) begin
                        run_nxt = 5'd0;
                    end else if (run_inc == LOCK_V) begin
                        state_nxt = LOCKED;
                        run_nxt   = 5'd0;
                    end else begin
                        run_nxt = run_inc;
                    end
                end
                LOCKED: begin
                    if (drop) begin
                        state_nxt = HUNT;
                        fill_nxt  = 3'd0;
                        run_nxt   = 5'd0;
                    end else if (miss) begin
                        run_nxt = run_inc;
                    end else begin
                        run_nxt = 5'd0;
                    end
                end
                default: begin
                    state_nxt = HUNT;
                    fill_nxt  = 3'd0;
                    run_nxt   = 5'd0;
                end
            endcase
        end
    end

`ifdef MSEQ_CHK_ERRCNT_EN
    logic [CNT_W-1:0] cnt;

    // Clear beats a same-cycle increment; count survives lock loss.
    always_ff @(posedge clk) begin
        if (!preset || err_clr) begin
            cnt <= '0;
        end else if (miss && (cnt != '1)) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign err_cnt = cnt;
`else
    logic unused_err_clr;
    assign unused_err_clr = err_clr;
    assign err_cnt        = '0;
`endif

endmodule

// File: tb/tb_mseq_checker.sv
// Directed bench for mseq_checker: default instance plus a CNT_W=2 / UNLOCK_N=31 instance.
// Expected outputs are queued per driven bit and compared one edge later.
module tb_mseq_checker;
    import mseq_checker_pkg::*;

    typedef struct packed {
        logic        locked;
        logic        err;
        logic [15:0] cnt;
    } exp_t;

`ifdef MSEQ_CHK_ERRCNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        preset = 1'b0;
    logic        bit_en = 1'b0;
    logic        din = 1'b0;
    logic        err_clr = 1'b0;
    logic        locked1, err1, locked2, err2;
    logic [15:0] cnt1;
    logic [1:0]  cnt2;

    exp_t q1[$];
    exp_t q2[$];
    logic seq [0:MSEQ_PERIOD-1];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   stepno = 0;
    int   p = 0;

    always #5 clk = ~clk;

    mseq_checker dut (
        .clk(clk), .preset(preset), .bit_en(bit_en), .din(din), .err_clr(err_clr),
        .locked(locked1), .err(err1), .err_cnt(cnt1)
    );

    mseq_checker #(.LOCK_N(8), .UNLOCK_N(31), .CNT_W(2)) dut2 (
        .clk(clk), .preset(preset), .bit_en(bit_en), .din(din), .err_clr(err_clr),
        .locked(locked2), .err(err2), .err_cnt(cnt2)
    );

    function automatic exp_t mk(input logic l, input logic e, input int c);
        exp_t x;
        x.locked = l;
        x.err    = e;
        x.cnt    = CNT_EN ? 16'(c) : 16'd0;
        return x;
    endfunction

    function automatic logic sbit(input int i);
        return seq[i % MSEQ_PERIOD];
    endfunction

    task automatic cmp(input string tag, input logic [15:0] got, input logic [15:0] want);
        n_cmp++;
        assert (got === want) else begin
            n_bad++;
            $error("FAIL %s step %0d: observed %0h expected %0h", tag, stepno, got, want);
        end
    endtask

    task automatic step(input logic en, input logic d, input logic clr,
                        input logic c1, input exp_t e1, input logic c2, input exp_t e2);
        bit_en  = en;
        din     = d;
        err_clr = clr;
        if (c1) q1.push_back(e1);
        if (c2) q2.push_back(e2);
        @(posedge clk);
        #1;
        stepno++;
        while (q1.size() > 0) begin
            exp_t e = q1.pop_front();
            cmp("dut.locked", {15'd0, locked1}, {15'd0, e.locked});
            cmp("dut.err", {15'd0, err1}, {15'd0, e.err});
            cmp("dut.err_cnt", cnt1, e.cnt);
        end
        while (q2.size() > 0) begin
            exp_t e = q2.pop_front();
            cmp("dut2.locked", {15'd0, locked2}, {15'd0, e.locked});
            cmp("dut2.err", {15'd0, err2}, {15'd0, e.err});
            cmp("dut2.err_cnt", {14'd0, cnt2}, e.cnt);
        end
    endtask

    task automatic do_reset();
        preset = 1'b0;
        step(0, 0, 0, 1, mk(0, 0, 0), 1, mk(0, 0, 0));
        preset = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < MSEQ_PERIOD; i++) begin
            seq[i] = (i < 5) ? 1'b1 : (seq[i-2] ^ seq[i-5]);
        end

        // Clean stream from reset: lock after the 13th bit, no errors for 100 periods.
        do_reset();
        for (int i = 1; i <= 100 * MSEQ_PERIOD; i++) begin
            step(1, sbit(p), 0, 1, mk(i >= 13, 0, 0), 1, mk(i >= 13, 0, 0));
            p++;
        end

        // One flipped bit: single err pulse, idle cycle drops err, stream stays clean.
        step(1, ~sbit(p), 0, 1, mk(1, 1, 1), 1, mk(1, 1, 1));
        p++;
        step(0, 0, 0, 1, mk(1, 0, 1), 1, mk(1, 0, 1));
        for (int i = 0; i < 20; i++) begin
            step(1, sbit(p), 0, 1, mk(1, 0, 1), 1, mk(1, 0, 1));
            p++;
        end

        // Four flipped bits: default instance unlocks and relocks; dut2 stays locked and saturates.
        do_reset();
        for (int i = 1; i <= 13; i++) begin
            step(1, sbit(p), 0, 1, mk(i >= 13, 0, 0), 1, mk(i >= 13, 0, 0));
            p++;
        end
        for (int k = 1; k <= 4; k++) begin
            step(1, ~sbit(p), 0, 1, mk(k < 4, 1, k), 1, mk(1, 1, (k < 3) ? k : 3));
            p++;
        end
        for (int j = 1; j <= 13; j++) begin
            step(1, sbit(p), 0, 1, mk(j >= 13, 0, 4), 1, mk(1, 0, 3));
            p++;
        end

        // All-zero input never locks.
        do_reset();
        for (int i = 0; i < 200; i++) begin
            step(1, 0, 0, 1, mk(0, 0, 0), 1, mk(0, 0, 0));
        end

        // Alternating bit_en with garbage din on idle cycles.
        do_reset();
        for (int k = 1; k <= 20; k++) begin
            step(1, sbit(p), 0, 1, mk(k >= 13, 0, 0), 1, mk(k >= 13, 0, 0));
            p++;
            step(0, 1'($urandom_range(0, 1)), 0, 1, mk(k >= 13, 0, 0), 1, mk(k >= 13, 0, 0));
        end

        // Continuous errors: dut2 saturates at 3, err_clr on a mismatch gives 0.
        for (int k = 1; k <= 6; k++) begin
            step(1, ~sbit(p), 0,
                 1, (k <= 4) ? mk(k < 4, 1, k) : mk(0, 0, 4),
                 1, mk(1, 1, (k < 3) ? k : 3));
            p++;
        end
        step(1, ~sbit(p), 1, 1, mk(0, 0, 0), 1, mk(1, 1, 0));
        p++;
        step(1, sbit(p), 0, 1, mk(0, 0, 0), 1, mk(1, 0, 0));
        p++;

        // Reset while dut2 is locked and seeing a mismatch.
        preset = 1'b0;
        step(1, ~sbit(p), 0, 1, mk(0, 0, 0), 1, mk(0, 0, 0));
        preset = 1'b1;
        step(0, 0, 0, 1, mk(0, 0, 0), 1, mk(0, 0, 0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
